keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 matrix keypad. It drives the column lines one at a time and samples the row lines. Each full scan is debounced, and the block emits one clean, registered key event per press and per release. It sits between the keypad pins and the display logic in the SSD/keypad top level. Its `key_valid` pulse directly replaces the debounce and pulse-detector chain used on the raw key-pressed level.

---
 rtl/keypad_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one column at a time, debounces whole-scan
// results and emits registered press/release events.
module keypad_scan_ctrl #(
    parameter int settle_cycles = 50_000,
    parameter int stable_scans  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_held
);
    localparam int dw = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    localparam int sw = (stable_scans > 0) ? $clog2(stable_scans + 1) : 1;
    localparam logic [dw-1:0] dwell_last = dw'(settle_cycles - 1);
    localparam logic [sw-1:0] stable_max = sw'(stable_scans);
    localparam logic [sw-1:0] stable_pre = sw'(stable_scans - 1);
    // Nibble {row, column} holds the hex value printed on that key.
    localparam logic [63:0] key_map = 64'hDEF0_C987_B654_A321;

    typedef enum logic {DRIVE, EVAL} state_t;
    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_kind_t;
    typedef struct packed {
        res_kind_t  kind;
        logic [3:0] code;
    } scan_res_t;

    localparam scan_res_t res_none = '{kind: RES_NONE, code: 4'h0};

    logic [3:0]    row_meta, row_sync;
    state_t        state, state_next;
    logic [1:0]    col_idx, col_idx_next;
    logic [dw-1:0] dwell, dwell_next;
    logic [15:0]   acc, acc_next;
    logic          paused, paused_next;
    logic [3:0]    col_next;
    scan_res_t     scan_res, cand, cand_next, accepted, accepted_next;
    logic [sw-1:0] stable_cnt, cnt_next;
    logic [3:0]    code_next, hit;
    logic          valid_next, release_next, held_next, reached;

    // acc bit {row, column} is 1 when that key was seen pressed this scan.
    always_comb begin
        scan_res = res_none;
        hit      = 4'h0;
        for (int i = 0; i < 16; i++)
            if (acc[i]) hit = 4'(i);
        if ($countones(acc) == 1)
            scan_res = '{kind: RES_KEY, code: key_map[{hit, 2'b00} +: 4]};
        else if (acc != '0)
            scan_res = '{kind: RES_MULTI, code: 4'h0};
    end

    // NOTE: every signal gets a default first, so no latch can be inferred.
    always_comb begin
        state_next    = state;
        col_idx_next  = col_idx;
        dwell_next    = dwell;
        acc_next      = acc;
        paused_next   = paused;
        col_next      = col;
        cand_next     = cand;
        cnt_next      = stable_cnt;
        accepted_next = accepted;
        code_next     = key_code;
        held_next     = key_held;
        valid_next    = 1'b0;
        release_next  = 1'b0;
        reached       = 1'b0;

        if (!scan_en) begin
            paused_next = 1'b1;
            col_next    = 4'b1111;
        end else if (paused) begin
            // Re-enable restarts the interrupted column dwell from zero.
            paused_next = 1'b0;
            dwell_next  = '0;
            col_next    = (state == DRIVE) ? ~(4'b0001 << col_idx) : 4'b1111;
        end else begin
            case (state)
                DRIVE: begin
                    if (dwell == dwell_last) begin
                        for (int r = 0; r < 4; r++)
                            acc_next[{2'(r), col_idx}] = ~row_sync[r];
                        dwell_next = '0;
                        if (col_idx == 2'd3) begin
                            state_next = EVAL;
                            col_next   = 4'b1111;
                        end else begin
                            col_idx_next = col_idx + 2'd1;
                            col_next     = ~(4'b0001 << (col_idx + 2'd1));
                        end
                    end else begin
                        dwell_next = dwell + dw'(1);
                    end
                end
                EVAL: begin
                    state_next   = DRIVE;
                    col_idx_next = 2'd0;
                    dwell_next   = '0;
                    acc_next     = '0;
                    col_next     = 4'b1110;
                    if (scan_res == cand) begin
                        if (stable_cnt != stable_max) cnt_next = stable_cnt + sw'(1);
                        reached = (stable_cnt == stable_pre);
                    end else begin
                        cand_next = scan_res;
                        cnt_next  = sw'(1);
                        reached   = (stable_scans == 1);
                    end
                    if (reached) begin
                        if (cand_next.kind == RES_KEY && cand_next != accepted) begin
                            accepted_next = cand_next;
                            code_next     = cand_next.code;
                            held_next     = 1'b1;
                            valid_next    = 1'b1;
                        end else if (cand_next.kind == RES_NONE && accepted.kind == RES_KEY) begin
                            accepted_next = res_none;
                            held_next     = 1'b0;
                            release_next  = 1'b1;
                        end
                    end
                end
                default: state_next = DRIVE;
            endcase
        end
    end

    // NOTE: registered state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta    <= 4'hF;
            row_sync    <= 4'hF;
            state       <= DRIVE;
            col_idx     <= 2'd0;
            dwell       <= '0;
            acc         <= '0;
            paused      <= 1'b0;
            col         <= 4'b1110;
            cand        <= res_none;
            stable_cnt  <= '0;
            accepted    <= res_none;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            row_meta    <= row;
            row_sync    <= row_meta;
            state       <= state_next;
            col_idx     <= col_idx_next;
            dwell       <= dwell_next;
            acc         <= acc_next;
            paused      <= paused_next;
            col         <= col_next;
            cand        <= cand_next;
            stable_cnt  <= cnt_next;
            accepted    <= accepted_next;
            key_code    <= code_next;
            key_valid   <= valid_next;
            key_release <= release_next;
            key_held    <= held_next;
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: emulated keypad matrix, scan-level reference
// model compared every cycle, plus directed scenario checks.
module tb_keypad_scan_ctrl;
    localparam int S = 4;
    localparam int N = 3;
    localparam int P = 4 * S + 1;

    logic       clk = 1'b0;
    logic       rst, scan_en;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_release, key_held;
    logic [15:0] keys;

    int n_checks = 0;
    int n_errors = 0;

    keypad_scan_ctrl #(.settle_cycles(S), .stable_scans(N)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid),
        .key_release(key_release), .key_held(key_held)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] m;
        m = 16'h0;
        m[r*4+c] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] col_for(input int p);
        return (p < 4 * S) ? ~(4'b0001 << (p / S)) : 4'b1111;
    endfunction

    // ---------------- reference model (scan-level view) ----------------
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    int          m_pos, m_last, m_run, m_acc;
    bit          m_paused;
    logic [15:0] m_hist0, m_hist1, m_scan;
    logic [3:0]  m_col, m_code;
    logic        m_held;
    logic [3:0]  exp_col, exp_code;
    logic        exp_valid, exp_rel, exp_held;
    bit          m_ready = 1'b0;

    always @(posedge clk) begin : model
        logic [15:0] seen;
        logic        v, rl;
        int          res, hit, cc;
        seen = m_hist1;
        m_hist1 = m_hist0;
        m_hist0 = keys;
        v = 1'b0;
        rl = 1'b0;
        if (rst) begin
            m_pos = 0; m_paused = 0; m_scan = '0;
            m_last = -1; m_run = 0; m_acc = -1;
            m_hist0 = '0; m_hist1 = '0;
            m_col = 4'b1110; m_code = 4'h0; m_held = 1'b0;
            m_ready <= 1'b1;
        end else if (!scan_en) begin
            m_paused = 1;
            m_col = 4'b1111;
        end else if (m_paused) begin
            m_paused = 0;
            if (m_pos < 4 * S) m_pos = (m_pos / S) * S;
            m_col = col_for(m_pos);
        end else begin
            if (m_pos == 4 * S) begin
                hit = 0;
                for (int i = 0; i < 16; i++) if (m_scan[i]) hit = i;
                if ($countones(m_scan) == 0) res = -1;
                else if ($countones(m_scan) == 1) res = int'(keymap[hit]);
                else res = -2;
                if (res == m_last) m_run++;
                else begin m_last = res; m_run = 1; end
                if (m_run == N) begin
                    if (res >= 0 && res != m_acc) begin
                        m_acc = res; m_code = 4'(res); m_held = 1'b1; v = 1'b1;
                    end else if (res == -1 && m_acc >= 0) begin
                        m_acc = -1; m_held = 1'b0; rl = 1'b1;
                    end
                end
                m_pos = 0;
                m_scan = '0;
            end else begin
                if (m_pos % S == S - 1) begin
                    cc = m_pos / S;
                    for (int r = 0; r < 4; r++)
                        if (seen[r*4+cc]) m_scan[r*4+cc] = 1'b1;
                end
                m_pos++;
            end
            m_col = col_for(m_pos);
        end
        exp_col   <= m_col;
        exp_code  <= m_code;
        exp_held  <= m_held;
        exp_valid <= v;
        exp_rel   <= rl;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ready) begin
            check("col", col, exp_col);
            check("key_code", key_code, exp_code);
            check("key_valid", key_valid, exp_valid);
            check("key_release", key_release, exp_rel);
            check("key_held", key_held, exp_held);
            check("pulse_exclusive", key_valid & key_release, 0);
        end
    end

    // Event counters used by the directed scenario checks.
    int         n_valid = 0, n_rel = 0, n_drop = 0;
    logic [3:0] last_code = 4'h0;
    logic       prev_held = 1'b0;
    always @(negedge clk) begin
        if (m_ready) begin
            if (key_valid === 1'b1) begin n_valid++; last_code = key_code; end
            if (key_release === 1'b1) n_rel++;
            if (prev_held === 1'b1 && key_held === 1'b0) n_drop++;
            prev_held = key_held;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int v0, r0, d0, cnt;
    bit found;

    initial begin
        rst = 1'b1; scan_en = 1'b1; keys = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_col", col, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_held", key_held, 0);
        check("rst_valid", key_valid, 0);
        check("rst_release", key_release, 0);

        // 1: single press of "6" then release
        v0 = n_valid; r0 = n_rel;
        keys = key_bit(1, 2);
        cycles(5 * P);
        check("s1_valid_count", n_valid - v0, 1);
        check("s1_code", last_code, 4'h6);
        check("s1_held", key_held, 1);
        keys = '0;
        cycles(5 * P);
        check("s1_release_count", n_rel - r0, 1);
        check("s1_valid_once", n_valid - v0, 1);
        check("s1_code_kept", key_code, 4'h6);
        check("s1_held_low", key_held, 0);

        // 2: "A" bouncing on alternate scans, then held
        v0 = n_valid; r0 = n_rel;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? key_bit(0, 3) : 16'h0;
            cycles(P);
        end
        check("s2_no_valid_bounce", n_valid - v0, 0);
        check("s2_no_release_bounce", n_rel - r0, 0);
        keys = key_bit(0, 3);
        cycles(5 * P);
        check("s2_valid_count", n_valid - v0, 1);
        check("s2_code", last_code, 4'hA);
        keys = '0;
        cycles(5 * P);

        // 3: "1" and "5" together, then "5" released
        v0 = n_valid; r0 = n_rel;
        keys = key_bit(0, 0) | key_bit(1, 1);
        cycles(6 * P);
        check("s3_multi_no_valid", n_valid - v0, 0);
        check("s3_multi_not_held", key_held, 0);
        keys = key_bit(0, 0);
        cycles(5 * P);
        check("s3_valid_count", n_valid - v0, 1);
        check("s3_code", last_code, 4'h1);
        check("s3_no_release", n_rel - r0, 0);
        keys = '0;
        cycles(5 * P);

        // 4: "0" then straight to "D"
        v0 = n_valid; r0 = n_rel; d0 = n_drop;
        keys = key_bit(3, 0);
        cycles(5 * P);
        check("s4_first_valid", n_valid - v0, 1);
        check("s4_first_code", last_code, 4'h0);
        keys = key_bit(3, 3);
        cycles(5 * P);
        check("s4_second_valid", n_valid - v0, 2);
        check("s4_second_code", last_code, 4'hD);
        check("s4_no_release", n_rel - r0, 0);
        check("s4_held_never_dropped", n_drop - d0, 0);
        check("s4_held", key_held, 1);
        keys = '0;
        cycles(5 * P);

        // 5: scan_en dropped mid-dwell on column 2 while "6" is held
        keys = key_bit(1, 2);
        cycles(5 * P);
        found = 1'b0;
        for (int i = 0; i < 3 * P && !found; i++) begin
            @(negedge clk);
            if (col == 4'b1011) found = 1'b1;
        end
        check("s5_reach_col2", found, 1);
        @(negedge clk);
        scan_en = 1'b0;
        v0 = n_valid; r0 = n_rel;
        cycles(2);
        check("s5_col_idle", col, 4'b1111);
        check("s5_held_frozen", key_held, 1);
        check("s5_code_frozen", key_code, 4'h6);
        cycles(8);
        check("s5_col_still_idle", col, 4'b1111);
        check("s5_no_pulses", (n_valid - v0) + (n_rel - r0), 0);
        @(negedge clk);
        scan_en = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (col == 4'b1011 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("s5_redrive_cycles", cnt, S);
        keys = '0;
        cycles(5 * P);

        // 6: reset while "9" is accepted and still held
        keys = key_bit(2, 2);
        cycles(5 * P);
        check("s6_pre_code", key_code, 4'h9);
        check("s6_pre_held", key_held, 1);
        v0 = n_valid; r0 = n_rel;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("s6_rst_col", col, 4'b1110);
        check("s6_rst_held", key_held, 0);
        check("s6_rst_code", key_code, 4'h0);
        check("s6_rst_pulses", key_valid | key_release, 0);
        cycles(3 * P - 1);
        check("s6_not_yet_valid", n_valid - v0, 0);
        cycles(2);
        check("s6_revalid", n_valid - v0, 1);
        check("s6_code", last_code, 4'h9);
        check("s6_no_release", n_rel - r0, 0);
        keys = '0;
        cycles(5 * P);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
